mem_bus: RTL and testbench

MEM_BUS -- requirements
Module: mem_bus

---
 rtl/mem_bus_pkg.sv | 33 +++
 rtl/mem_bus_result_fifo.sv | 51 +++++
 rtl/mem_bus.sv | 78 +++++++
 tb/tb_mem_bus.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants for mem_bus: address regions, memory depths, status layout.
// The status register contents are built here; used only when MEM_BUS_STATUS_EN is defined.
package mem_bus_pkg;

  typedef enum logic [3:0] {
    REGION_RAM  = 4'h0,
    REGION_FIFO = 4'h1
  } region_e;

  localparam int unsigned RAM_DEPTH  = 256;
  localparam int unsigned RAM_AW     = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_AW    = 3;

  localparam int unsigned ST_OVF_BIT   = 6;
  localparam int unsigned ST_FULL_BIT  = 5;
  localparam int unsigned ST_EMPTY_BIT = 4;

  localparam logic [15:0] ADDR_PUSH   = 16'h1000;
  localparam logic [15:0] ADDR_STATUS = 16'h1001;

  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic [3:0] count);
    logic [31:0] w;
    w               = '0;
    w[3:0]          = count;
    w[ST_EMPTY_BIT] = empty;
    w[ST_FULL_BIT]  = full;
    w[ST_OVF_BIT]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_result_fifo.sv
// 8-deep result FIFO with wrap-bit pointers and a 0..8 occupancy count.
module result_fifo
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count
);

  logic [31:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]) && (wptr[FIFO_AW] != rptr[FIFO_AW]);
  assign empty = (wptr == rptr);

  // A pop frees the head slot in the same edge, so a push while full is accepted then.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign rdata = empty ? '0 : mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus.sv
// Processor-side bus: 256x32 RAM, result FIFO push port and status register.
// Define MEM_BUS_STATUS_EN to enable status readback and the ovf-clear write.
module mem_bus
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ADDR,
  input  logic [31:0] DOUT,
  input  logic        W,
  output logic [31:0] DIN,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        ovf
);

  logic [31:0] ram [RAM_DEPTH];
  logic        ram_sel;
  logic        push_sel;
  logic        stat_sel;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  fifo_count;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{ADDR[31:16], ADDR[11:8]};

  assign ram_sel  = (ADDR[15:12] == REGION_RAM);
  assign push_sel = (ADDR[15:12] == REGION_FIFO) && !ADDR[0];
  assign stat_sel = (ADDR[15:12] == REGION_FIFO) &&  ADDR[0];

  assign fifo_push = W && push_sel;
  assign fifo_pop  = res_valid && res_ready;
  assign res_valid = !fifo_empty;

  result_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (DOUT),
    .rdata (res_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (W && ram_sel) ram[ADDR[RAM_AW-1:0]] <= DOUT;
  end

  always_comb begin
    rd_data = '0;
    if (ram_sel) rd_data = ram[ADDR[RAM_AW-1:0]];
`ifdef MEM_BUS_STATUS_EN
    else if (stat_sel) rd_data = status_word(ovf, fifo_full, fifo_empty, fifo_count);
`endif
  end

  // RAM array is read before its write lands, so read-during-write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) DIN <= '0;
    else        DIN <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) ovf <= 1'b1;
`ifdef MEM_BUS_STATUS_EN
    else if (W && stat_sel && DOUT[0]) ovf <= 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_bus.sv
// Directed self-checking bench for mem_bus; expected values are hand-computed constants.
module tb_mem_bus;

  logic        clk;
  logic        rst_n;
  logic [31:0] ADDR;
  logic [31:0] DOUT;
  logic        W;
  logic [31:0] DIN;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  mem_bus dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ADDR      (ADDR),
    .DOUT      (DOUT),
    .W         (W),
    .DIN       (DIN),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

`ifdef MEM_BUS_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  initial begin
    rst_n = 1'b0; W = 1'b0; ADDR = '0; DOUT = '0; res_ready = 1'b0;
    #1;
    chk("rst_din", DIN, 32'h0);
    chk("rst_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // RAM write then read, latency 1
    ADDR = 32'h5; DOUT = 32'hDEADBEEF; W = 1'b1; tick();
    W = 1'b0; tick();
    chk("ram_rd", DIN, 32'hDEADBEEF);
    ADDR = 32'h3000; #1;
    chk("din_held", DIN, 32'hDEADBEEF);
    tick();
    chk("unmapped_rd", DIN, 32'h0);

    // read-during-write returns old contents
    ADDR = 32'h5; DOUT = 32'h12345678; W = 1'b1; tick();
    chk("rdw_old", DIN, 32'hDEADBEEF);
    W = 1'b0; tick();
    chk("rdw_new", DIN, 32'h12345678);

    // unmapped write is ignored
    ADDR = 32'h0; DOUT = 32'h0BADF00D; W = 1'b1; tick();
    ADDR = 32'h3000; DOUT = 32'hFFFFFFFF; tick();
    W = 1'b0;
    chk("unmapped_wr_fifo", {31'h0, res_valid}, 32'h0);
    ADDR = 32'h0; tick();
    chk("unmapped_wr_ram", DIN, 32'h0BADF00D);
    ADDR = 32'h1000; tick();
    chk("push_port_rd", DIN, 32'h0);
    ADDR = 32'h1001; tick();
    chk("status_idle", DIN, STAT ? 32'h10 : 32'h0);

    // push 1..9 with no consumer: overflow
    res_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      ADDR = 32'h1000; DOUT = i; W = 1'b1;
      if (i == 1) chk("no_bypass", {31'h0, res_valid}, 32'h0);
      tick();
      if (i == 1) begin
        chk("first_valid", {31'h0, res_valid}, 32'h1);
        chk("first_data", res_data, 32'h1);
      end
      if (i == 8) chk("full_no_ovf", {31'h0, ovf}, 32'h0);
    end
    W = 1'b0;
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    ADDR = 32'h1001; tick();
    chk("status_full", DIN, STAT ? 32'h68 : 32'h0);
    ADDR = 32'h3000; res_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_%0d", k), res_data, k);
      tick();
    end
    res_ready = 1'b0;
    chk("drained_valid", {31'h0, res_valid}, 32'h0);
    chk("drained_data", res_data, 32'h0);
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);

    // reset mid-operation with 5 queued and a read pending
    for (int i = 0; i < 5; i++) begin
      ADDR = 32'h1000; DOUT = 32'h21 + i; W = 1'b1; tick();
    end
    W = 1'b0; ADDR = 32'h5; tick();
    chk("pre_rst_din", DIN, 32'h12345678);
    #2 rst_n = 1'b0; #1;
    chk("async_din", DIN, 32'h0);
    chk("async_valid", {31'h0, res_valid}, 32'h0);
    chk("async_data", res_data, 32'h0);
    chk("async_ovf", {31'h0, ovf}, 32'h0);
    tick();
    rst_n = 1'b1;
    ADDR = 32'h1000; DOUT = 32'h77; W = 1'b1; tick();
    W = 1'b0; ADDR = 32'h3000;
    chk("post_rst_data", res_data, 32'h77);
    res_ready = 1'b1; tick();
    chk("post_rst_alone", {31'h0, res_valid}, 32'h0);
    res_ready = 1'b0;

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      ADDR = 32'h1000; DOUT = 32'h10 + i; W = 1'b1; tick();
    end
    chk("full_head", res_data, 32'h10);
    ADDR = 32'h1000; DOUT = 32'hA5; W = 1'b1; res_ready = 1'b1; tick();
    W = 1'b0; res_ready = 1'b0;
    chk("fullpop_ovf", {31'h0, ovf}, 32'h0);
    chk("fullpop_head", res_data, 32'h11);
    ADDR = 32'h1001; tick();
    chk("status_fullpop", DIN, STAT ? 32'h28 : 32'h0);
    ADDR = 32'h3000; res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fp_drain_%0d", k), res_data, (k == 7) ? 32'hA5 : 32'h11 + k);
      tick();
    end
    res_ready = 1'b0;
    chk("fp_empty", {31'h0, res_valid}, 32'h0);

    // overflow, leave 3 entries, then status read and ovf clear
    for (int i = 1; i <= 9; i++) begin
      ADDR = 32'h1000; DOUT = i; W = 1'b1; tick();
    end
    W = 1'b0; ADDR = 32'h3000; res_ready = 1'b1;
    repeat (5) tick();
    res_ready = 1'b0;
    chk("three_left_head", res_data, 32'h6);
    ADDR = 32'h1001; tick();
    chk("status_43", DIN, STAT ? 32'h43 : 32'h0);
    DOUT = 32'h1; W = 1'b1; tick();
    W = 1'b0;
    chk("ovf_clear", {31'h0, ovf}, STAT ? 32'h0 : 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
